stack_unit: RTL and testbench

Self-managing data/return stack for the CPU core. Holds the top-of-stack in a register and the deeper entries in a register array, and maintains its own pointer and fill level from a 2-bit signed move command. Supports push, pop and drop-two, plus an optional top load, in one cycle. Stack-pointer arithmetic is taken out of the core datapath, and the block reports full/empty and, optionally, guarded overflow/underflow.

---
 rtl/stack_unit_pkg.sv | 15 +
 rtl/stack_mem.sv | 31 +++
 rtl/stack_unit.sv | 170 +++++++++++++++++
 tb/tb_stack_unit.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_unit_pkg.sv
// stack_unit shared definitions
// move encodings and default geometry
package stack_unit_pkg;

   localparam int STACK_WIDTH = 16;
   localparam int STACK_DEPTH = 4;

   typedef enum logic [1:0] {
      MOVE_HOLD  = 2'b00,
      MOVE_PUSH  = 2'b01,
      MOVE_DROP2 = 2'b10,
      MOVE_POP   = 2'b11
   } move_e;

endpackage

// File: rtl/stack_mem.sv
// stack_mem: register array below the top register
// one sync write port, async reads for next and the entry under it
module stack_mem
   import stack_unit_pkg::*;
#(
   parameter int WIDTH = STACK_WIDTH,
   parameter int DEPTH = STACK_DEPTH
) (
   input  logic             clock,
   input  logic             wr_en,
   input  logic [DEPTH-1:0] wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [DEPTH-1:0] rd_addr,
   output logic [WIDTH-1:0] rd_data,
   input  logic [DEPTH-1:0] rd2_addr,
   output logic [WIDTH-1:0] rd2_data
);

   logic [WIDTH-1:0] mem [2**DEPTH];

   // single write per cycle, contents never reset
   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data  = mem[rd_addr];
   assign rd2_data = mem[rd2_addr];

endmodule

// File: rtl/stack_unit.sv
// stack_unit: self-managing stack with top register
// STACK_GUARD_EN enables guarded overflow/underflow handling
module stack_unit
   import stack_unit_pkg::*;
#(
   parameter int WIDTH = STACK_WIDTH,
   parameter int DEPTH = STACK_DEPTH
) (
   input  logic             clock,
   input  logic             active_low_reset,
   input  logic             clear,
   input  logic [1:0]       move,
   input  logic             load_top,
   input  logic [WIDTH-1:0] top_in,
   output logic [WIDTH-1:0] top,
   output logic [WIDTH-1:0] next,
   output logic [DEPTH:0]   level,
   output logic             full,
   output logic             empty,
   output logic             overflow,
   output logic             underflow
);

   localparam logic [DEPTH:0]   LVL_MAX = {1'b1, {DEPTH{1'b0}}};
   localparam logic [DEPTH:0]   LVL_ONE = (DEPTH+1)'(1);
   localparam logic [DEPTH:0]   LVL_TWO = (DEPTH+1)'(2);
   localparam logic [DEPTH-1:0] SP_ONE  = DEPTH'(1);
   localparam logic [DEPTH-1:0] SP_TWO  = DEPTH'(2);

   move_e mv;

   logic [DEPTH-1:0] sp_q;
   logic [DEPTH-1:0] sp_d;
   logic [DEPTH:0]   level_q;
   logic [DEPTH:0]   lvl_d;
   logic [WIDTH-1:0] top_q;
   logic [WIDTH-1:0] top_d;

   logic             push_ok;
   logic             wr_en;
   logic [WIDTH-1:0] mem_next;
   logic [WIDTH-1:0] mem_below;

   logic             push_blk;
   logic             pop_blk;
   logic             drop_blk;

   assign mv    = move_e'(move);
   assign full  = (level_q == LVL_MAX);
   assign empty = (level_q == '0);
   assign level = level_q;
   assign top   = top_q;
   assign next  = mem_next;

   // a write held off by reset is dropped
   assign wr_en = push_ok & ~clear & active_low_reset;

   stack_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_mem (
      .clock    (clock),
      .wr_en    (wr_en),
      .wr_addr  (sp_q + SP_ONE),
      .wr_data  (top_q),
      .rd_addr  (sp_q),
      .rd_data  (mem_next),
      .rd2_addr (sp_q - SP_ONE),
      .rd2_data (mem_below)
   );

`ifdef STACK_GUARD_EN
   logic ovf_q;
   logic unf_q;
   logic ovf_set;
   logic unf_set;

   assign push_blk = full;
   assign pop_blk  = empty;
   assign drop_blk = (level_q < LVL_TWO);

   assign ovf_set = (mv == MOVE_PUSH) & push_blk;
   assign unf_set = ((mv == MOVE_POP) & pop_blk)
                  | ((mv == MOVE_DROP2) & drop_blk);

   // sticky error flags, cleared only by clear or reset
   always_ff @(posedge clock or negedge active_low_reset) begin
      if (!active_low_reset) begin
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else if (clear) begin
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_q | ovf_set;
         unf_q <= unf_q | unf_set;
      end
   end

   assign overflow  = ovf_q;
   assign underflow = unf_q;
`else
   assign push_blk  = 1'b0;
   assign pop_blk   = 1'b0;
   assign drop_blk  = 1'b0;
   assign overflow  = 1'b0;
   assign underflow = 1'b0;
`endif

   // next pointer, level and top from the move command
   always_comb begin
      sp_d    = sp_q;
      lvl_d   = level_q;
      top_d   = load_top ? top_in : top_q;
      push_ok = 1'b0;
      unique case (mv)
         MOVE_PUSH: begin
            if (push_blk) begin
               top_d = top_q;
            end else begin
               push_ok = 1'b1;
               sp_d    = sp_q + SP_ONE;
               lvl_d   = full ? level_q : level_q + LVL_ONE;
            end
         end
         MOVE_POP: begin
            if (pop_blk) begin
               top_d = top_q;
            end else begin
               sp_d  = sp_q - SP_ONE;
               lvl_d = empty ? level_q : level_q - LVL_ONE;
               if (!load_top) begin
                  top_d = mem_next;
               end
            end
         end
         MOVE_DROP2: begin
            if (drop_blk) begin
               top_d = top_q;
            end else begin
               sp_d  = sp_q - SP_TWO;
               lvl_d = (level_q < LVL_TWO) ? '0 : level_q - LVL_TWO;
               if (!load_top) begin
                  top_d = mem_below;
               end
            end
         end
         default: begin
         end
      endcase
   end

   // state registers; sp parks one below address 0 when empty
   always_ff @(posedge clock or negedge active_low_reset) begin
      if (!active_low_reset) begin
         sp_q    <= '1;
         level_q <= '0;
         top_q   <= '0;
      end else if (clear) begin
         sp_q    <= '1;
         level_q <= '0;
         top_q   <= '0;
      end else begin
         sp_q    <= sp_d;
         level_q <= lvl_d;
         top_q   <= top_d;
      end
   end

endmodule

// File: tb/tb_stack_unit.sv
// tb_stack_unit: directed stimulus, queue model of stack contents
// works with or without STACK_GUARD_EN
module tb_stack_unit;
   import stack_unit_pkg::*;

   localparam int W   = 16;
   localparam int D   = 2;
   localparam int CAP = 4;

`ifdef STACK_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic         clock = 1'b0;
   logic         active_low_reset = 1'b1;
   logic         clear = 1'b0;
   logic [1:0]   move = MOVE_HOLD;
   logic         load_top = 1'b0;
   logic [W-1:0] top_in = '0;
   logic [W-1:0] top;
   logic [W-1:0] next;
   logic [D:0]   level;
   logic         full;
   logic         empty;
   logic         overflow;
   logic         underflow;

   int checks   = 0;
   int failures = 0;
   bit cmp_on   = 1'b0;

   logic [W-1:0] q[$];
   logic [W-1:0] m_top = '0;
   bit           m_known = 1'b0;
   bit           m_ovf = 1'b0;
   bit           m_unf = 1'b0;

   stack_unit #(
      .WIDTH (W),
      .DEPTH (D)
   ) dut (
      .clock            (clock),
      .active_low_reset (active_low_reset),
      .clear            (clear),
      .move             (move),
      .load_top         (load_top),
      .top_in           (top_in),
      .top              (top),
      .next             (next),
      .level            (level),
      .full             (full),
      .empty            (empty),
      .overflow         (overflow),
      .underflow        (underflow)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h t=%0t",
                  name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_top   = '0;
      m_known = 1'b1;
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
   endtask

   task automatic model_step();
      bit           l;
      logic [W-1:0] v;
      l = load_top;
      v = top_in;
      if (!active_low_reset || clear) begin
         model_reset();
      end else begin
         case (move)
            MOVE_HOLD: if (l) m_top = v;
            MOVE_PUSH: begin
               if (GUARD && q.size() == CAP) begin
                  m_ovf = 1'b1;
               end else begin
                  q.push_back(m_top);
                  if (q.size() > CAP) void'(q.pop_front());
                  if (l) m_top = v;
               end
            end
            MOVE_POP: begin
               if (q.size() == 0) begin
                  if (GUARD) m_unf = 1'b1;
                  else begin
                     m_known = l;
                     if (l) m_top = v;
                  end
               end else begin
                  m_top   = q.pop_back();
                  m_known = 1'b1;
                  if (l) m_top = v;
               end
            end
            default: begin
               if (q.size() < 2) begin
                  if (GUARD) m_unf = 1'b1;
                  else begin
                     q.delete();
                     m_known = l;
                     if (l) m_top = v;
                  end
               end else begin
                  void'(q.pop_back());
                  m_top   = q.pop_back();
                  m_known = 1'b1;
                  if (l) m_top = v;
               end
            end
         endcase
      end
   endtask

   initial begin
      forever begin
         @(posedge clock or negedge active_low_reset);
         model_step();
      end
   end

   initial begin
      forever begin
         @(negedge clock);
         if (cmp_on) begin
            chk("m_level", 32'(level), 32'(q.size()));
            chk("m_full", 32'(full), 32'(q.size() == CAP));
            chk("m_empty", 32'(empty), 32'(q.size() == 0));
            chk("m_overflow", 32'(overflow), 32'(m_ovf));
            chk("m_underflow", 32'(underflow), 32'(m_unf));
            if (m_known) chk("m_top", 32'(top), 32'(m_top));
            if (q.size() > 0) chk("m_next", 32'(next), 32'(q[$]));
         end
      end
   end

   task automatic cmd(input logic [1:0] mv, input bit ld,
                      input logic [W-1:0] din, input bit clr);
      move     = mv;
      load_top = ld;
      top_in   = din;
      clear    = clr;
      @(posedge clock);
      #1;
      move     = MOVE_HOLD;
      load_top = 1'b0;
      top_in   = '0;
      clear    = 1'b0;
   endtask

   initial begin
      #1 active_low_reset = 1'b0;
      #1;
      chk("rst_top", 32'(top), 32'h0);
      chk("rst_level", 32'(level), 32'h0);
      chk("rst_empty", 32'(empty), 32'h1);
      chk("rst_full", 32'(full), 32'h0);
      @(negedge clock);
      active_low_reset = 1'b1;
      cmp_on = 1'b1;
      @(posedge clock);
      #1;

      cmd(MOVE_HOLD, 1'b1, 16'h0001, 1'b0);
      cmd(MOVE_PUSH, 1'b1, 16'h0002, 1'b0);
      cmd(MOVE_PUSH, 1'b1, 16'h0003, 1'b0);
      chk("p3_top", 32'(top), 32'h0003);
      chk("p3_next", 32'(next), 32'h0002);
      chk("p3_level", 32'(level), 32'h2);
      chk("p3_empty", 32'(empty), 32'h0);

      cmd(MOVE_POP, 1'b0, '0, 1'b0);
      cmd(MOVE_POP, 1'b0, '0, 1'b0);
      chk("pop_top", 32'(top), 32'h0001);
      chk("pop_level", 32'(level), 32'h0);
      chk("pop_empty", 32'(empty), 32'h1);

      for (int i = 0; i < 4; i++) begin
         cmd(MOVE_PUSH, 1'b1, 16'(16'hA0 + i), 1'b0);
      end
      chk("fill_full", 32'(full), 32'h1);
      chk("fill_top", 32'(top), 32'h00A3);
      cmd(MOVE_PUSH, 1'b1, 16'h00A4, 1'b0);
      chk("ovf_top", 32'(top), GUARD ? 32'h00A3 : 32'h00A4);
      chk("ovf_flag", 32'(overflow), 32'(GUARD));
      chk("ovf_level", 32'(level), 32'h4);
      chk("ovf_next", 32'(next), GUARD ? 32'h00A2 : 32'h00A3);

      for (int i = 0; i < 3; i++) begin
         cmd(MOVE_POP, 1'b0, '0, 1'b0);
      end
      chk("l1_top", 32'(top), GUARD ? 32'h00A0 : 32'h00A1);
      chk("l1_next", 32'(next), GUARD ? 32'h0001 : 32'h00A0);
      chk("l1_level", 32'(level), 32'h1);

      cmd(MOVE_DROP2, 1'b1, 16'h7777, 1'b0);
      chk("d2_top", 32'(top), GUARD ? 32'h00A0 : 32'h7777);
      chk("d2_level", 32'(level), GUARD ? 32'h1 : 32'h0);
      chk("d2_unf", 32'(underflow), 32'(GUARD));

      cmd(MOVE_HOLD, 1'b1, 16'h5555, 1'b0);
      chk("hold_top", 32'(top), 32'h5555);
      chk("hold_level", 32'(level), GUARD ? 32'h1 : 32'h0);

      cmd(MOVE_PUSH, 1'b1, 16'h9999, 1'b1);
      chk("clr_top", 32'(top), 32'h0);
      chk("clr_level", 32'(level), 32'h0);
      chk("clr_ovf", 32'(overflow), 32'h0);
      chk("clr_unf", 32'(underflow), 32'h0);

      cmd(MOVE_PUSH, 1'b1, 16'h0011, 1'b0);
      cmd(MOVE_PUSH, 1'b1, 16'h0022, 1'b0);
      move     = MOVE_PUSH;
      load_top = 1'b1;
      top_in   = 16'h0033;
      #2 active_low_reset = 1'b0;
      #1;
      chk("mid_top", 32'(top), 32'h0);
      chk("mid_level", 32'(level), 32'h0);
      chk("mid_empty", 32'(empty), 32'h1);
      @(negedge clock);
      move             = MOVE_HOLD;
      load_top         = 1'b0;
      active_low_reset = 1'b1;
      @(posedge clock);
      #1;
      cmd(MOVE_HOLD, 1'b1, 16'h0BEE, 1'b0);
      cmd(MOVE_PUSH, 1'b1, 16'h00D0, 1'b0);
      chk("rp_top", 32'(top), 32'h00D0);
      chk("rp_next", 32'(next), 32'h0BEE);
      chk("rp_level", 32'(level), 32'h1);
      chk("rp_addr0", 32'(dut.u_mem.mem[0]), 32'h0BEE);

      @(negedge clock);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
